// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM-stage bus controller with byte-lane steering, load extraction and timeout
module mem_access_stage #(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [1:0]        length,
  input  logic              sign,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_be,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata,
  output logic [31:0]       rdata,
  output logic              mem_stall,
  output logic              misalign,
  output logic              bus_err
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state_q, state_d;
  logic req_q, req_d, we_q, we_d, err_q, err_d, sign_q, sign_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0] wd_q, wd_d, rdata_q, rdata_d;
  logic [3:0] be_q, be_d;
  logic [1:0] off_q, off_d, len_q, len_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic op, mis, go, tmo;
  logic [3:0] be;
  logic [31:0] wd, ld;
  logic [7:0] bsel;
  logic [15:0] hsel;
  logic unused;
  assign unused = ^addr[31:ADDR_W];
  always_comb begin
    op   = memread | memwrite;
    mis  = (length == 2'b11) | ((length == 2'b10) & (addr[1:0] != 2'b00)) | ((length == 2'b01) & addr[0]);
    go   = (state_q == IDLE) & op & ~mis;
    be   = length == 2'b00 ? 4'b0001 << addr[1:0] : length == 2'b01 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wd   = ~memwrite ? 32'h0 : length == 2'b00 ? {4{wdata[7:0]}} : length == 2'b01 ? {2{wdata[15:0]}} : wdata;
    bsel = off_q == 2'd0 ? bus_rdata[7:0] : off_q == 2'd1 ? bus_rdata[15:8] : off_q == 2'd2 ? bus_rdata[23:16] : bus_rdata[31:24];
    hsel = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    ld   = len_q == 2'b00 ? {{24{sign_q & bsel[7]}}, bsel} : len_q == 2'b01 ? {{16{sign_q & hsel[15]}}, hsel} : bus_rdata;
    tmo  = cnt_q == CW'(TIMEOUT - 1);
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    be_d    = be_q;
    off_d   = off_q;
    len_d   = len_q;
    sign_d  = sign_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    if (go) begin
      state_d = ACCESS;
      req_d   = 1'b1;
      we_d    = memwrite;
      addr_d  = {addr[ADDR_W-1:2], 2'b00};
      wd_d    = wd;
      be_d    = be;
      off_d   = addr[1:0];
      len_d   = length;
      sign_d  = sign;
      err_d   = 1'b0;
      cnt_d   = '0;
    end else if (state_q == ACCESS) begin
      if (bus_ack) begin
        state_d = DONE;
        req_d   = 1'b0;
        rdata_d = we_q ? rdata_q : ld;
      end else if (tmo) begin
        state_d = DONE;
        req_d   = 1'b0;
        err_d   = 1'b1;
        rdata_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
      be_q    <= '0;
      off_q   <= '0;
      len_q   <= '0;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      be_q    <= be_d;
      off_q   <= off_d;
      len_q   <= len_d;
      sign_q  <= sign_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end
  assign bus_req   = req_q;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wd_q;
  assign bus_be    = be_q;
  assign bus_err   = err_q;
  assign rdata     = rdata_q;
  assign mem_stall = ~rst & (go | (state_q == ACCESS));
  assign misalign  = ~rst & (state_q == IDLE) & op & mis;
endmodule
